// File: rtl/pipe_stage_elastic_pkg.sv
// Shared pipeline definitions: control bit indices, data field layout
// and the occupancy encoding used by the elastic stage register.
package pipe_pkg;

    localparam int CTRL_W_DEF    = 5;
    localparam int DATA_W_DEF    = 128;

    localparam int CTRL_MEMWR    = 0;
    localparam int CTRL_BRANCH   = 1;
    localparam int CTRL_JUMP     = 2;
    localparam int CTRL_MEMTOREG = 3;
    localparam int CTRL_REGWR    = 4;

    localparam int FLD_W         = 32;
    localparam int OFF_BUSB      = 0;
    localparam int OFF_ALUOUT    = 32;
    localparam int OFF_TARGET    = 64;
    localparam int OFF_RD        = 96;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_t;

    // The skid entry is only ever valid while main is valid
    function automatic occ_t occ_of(input logic mv, input logic sv);
        if (sv)
            return ST_FULL;
        else if (mv)
            return ST_ONE;
        else
            return ST_EMPTY;
    endfunction

endpackage

// File: rtl/pipe_stage_elastic_entry.sv
// One pipeline slot: valid, control and data registers.
// Priority is flush over load over drop; flush leaves data untouched.
module pipe_entry
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = DATA_W_DEF
)(
    input  logic              CLK,
    input  logic              Resetn,
    input  logic              i_load,
    input  logic              i_drop,
    input  logic              i_flush,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;

    always_ff @(negedge CLK or negedge Resetn) begin
        if (!Resetn) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_ctrl  <= i_ctrl;
        end else if (i_drop) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(negedge CLK or negedge Resetn) begin
        if (!Resetn)
            r_data <= '0;
        else if (i_load && !i_flush)
            r_data <= i_data;
    end

    assign o_valid = r_valid;
    assign o_ctrl  = r_ctrl;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage register with valid/ready handshake, flush,
// optional two-entry skid buffer and a saturating bubble counter.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
)(
    input  logic              CLK,
    input  logic              Resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              w_accept;
    logic              w_retire;
    logic              w_main_v;
    logic [CTRL_W-1:0] w_main_ctrl;
    logic [DATA_W-1:0] w_main_data;
    logic [CNT_W-1:0]  r_bubble;

    assign w_accept = in_valid & in_ready;
    assign w_retire = out_valid & out_ready;

    generate
        if (SKID != 0) begin : g_skid
            logic              w_skid_v;
            logic [CTRL_W-1:0] w_skid_ctrl;
            logic [DATA_W-1:0] w_skid_data;
            logic              w_main_load;
            logic              w_main_drop;
            logic              w_from_skid;
            logic              w_skid_load;
            logic              w_skid_drop;
            occ_t              w_occ;

            assign w_occ = occ_of(w_main_v, w_skid_v);

            always_comb begin
                w_main_load = 1'b0;
                w_main_drop = 1'b0;
                w_from_skid = 1'b0;
                w_skid_load = 1'b0;
                w_skid_drop = 1'b0;
                unique case (w_occ)
                    ST_EMPTY: begin
                        w_main_load = w_accept;
                    end
                    ST_ONE: begin
                        if (w_retire) begin
                            w_main_load = w_accept;
                            w_main_drop = !w_accept;
                        end else begin
                            w_skid_load = w_accept;
                        end
                    end
                    ST_FULL: begin
                        w_main_load = w_retire;
                        w_from_skid = w_retire;
                        w_skid_drop = w_retire;
                    end
                    default: begin
                        w_main_load = 1'b0;
                    end
                endcase
            end

            pipe_entry #(
                .CTRL_W (CTRL_W),
                .DATA_W (DATA_W)
            ) u_main (
                .CLK     (CLK),
                .Resetn  (Resetn),
                .i_load  (w_main_load),
                .i_drop  (w_main_drop),
                .i_flush (flush),
                .i_ctrl  (w_from_skid ? w_skid_ctrl : in_ctrl),
                .i_data  (w_from_skid ? w_skid_data : in_data),
                .o_valid (w_main_v),
                .o_ctrl  (w_main_ctrl),
                .o_data  (w_main_data)
            );

            pipe_entry #(
                .CTRL_W (CTRL_W),
                .DATA_W (DATA_W)
            ) u_skid (
                .CLK     (CLK),
                .Resetn  (Resetn),
                .i_load  (w_skid_load),
                .i_drop  (w_skid_drop),
                .i_flush (flush),
                .i_ctrl  (in_ctrl),
                .i_data  (in_data),
                .o_valid (w_skid_v),
                .o_ctrl  (w_skid_ctrl),
                .o_data  (w_skid_data)
            );

            // Registered ready: never a combinational path from out_ready
            assign in_ready = !w_skid_v;
        end else begin : g_single
            assign in_ready = !w_main_v | out_ready;

            pipe_entry #(
                .CTRL_W (CTRL_W),
                .DATA_W (DATA_W)
            ) u_main (
                .CLK     (CLK),
                .Resetn  (Resetn),
                .i_load  (w_accept),
                .i_drop  (w_retire),
                .i_flush (flush),
                .i_ctrl  (in_ctrl),
                .i_data  (in_data),
                .o_valid (w_main_v),
                .o_ctrl  (w_main_ctrl),
                .o_data  (w_main_data)
            );
        end
    endgenerate

    always_ff @(negedge CLK or negedge Resetn) begin
        if (!Resetn)
            r_bubble <= '0;
        else if (!out_valid && (r_bubble != '1))
            r_bubble <= r_bubble + CNT_W'(1);
    end

    assign out_valid  = w_main_v;
    assign out_ctrl   = w_main_ctrl & {CTRL_W{w_main_v}};
    assign out_data   = w_main_data;
    assign bubble_cnt = r_bubble;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: skid and single-entry instances checked
// against a queue model every cycle, plus directed literal scenarios.
module tb_pipe_stage_elastic;
    import pipe_pkg::*;

    localparam int CW     = 5;
    localparam int DW     = 128;
    localparam int B0_MAX = 15;
    localparam int B1_MAX = 65535;

    logic          CLK = 1'b0;
    logic          Resetn = 1'b1;
    logic          in_valid = 1'b0;
    logic          flush = 1'b0;
    logic          out_ready = 1'b0;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;

    logic          rdy1, ov1, rdy0, ov0;
    logic [CW-1:0] oc1, oc0;
    logic [DW-1:0] od1, od0;
    logic [15:0]   bc1;
    logic [3:0]    bc0;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    ent_t q1[$];
    ent_t q0[$];
    int   b1 = 0;
    int   b0 = 0;

    pipe_stage_elastic #(
        .CTRL_W (CW), .DATA_W (DW), .SKID (1), .CNT_W (16)
    ) dut1 (
        .CLK        (CLK),
        .Resetn     (Resetn),
        .in_valid   (in_valid),
        .in_ready   (rdy1),
        .in_ctrl    (in_ctrl),
        .in_data    (in_data),
        .flush      (flush),
        .out_valid  (ov1),
        .out_ready  (out_ready),
        .out_ctrl   (oc1),
        .out_data   (od1),
        .bubble_cnt (bc1)
    );

    pipe_stage_elastic #(
        .CTRL_W (CW), .DATA_W (DW), .SKID (0), .CNT_W (4)
    ) dut0 (
        .CLK        (CLK),
        .Resetn     (Resetn),
        .in_valid   (in_valid),
        .in_ready   (rdy0),
        .in_ctrl    (in_ctrl),
        .in_data    (in_data),
        .flush      (flush),
        .out_valid  (ov0),
        .out_ready  (out_ready),
        .out_ctrl   (oc0),
        .out_data   (od0),
        .bubble_cnt (bc0)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Reference model: a FIFO of capacity 2 (skid) or 1 (single)
    always @(negedge Resetn) begin
        q1.delete();
        q0.delete();
        b1 = 0;
        b0 = 0;
    end

    always @(negedge CLK) begin
        bit   a1, r1, a0, r0;
        ent_t e;
        if (Resetn) begin
            e.c = in_ctrl;
            e.d = in_data;
            a1 = in_valid && (q1.size() < 2);
            r1 = (q1.size() > 0) && out_ready;
            a0 = in_valid && ((q0.size() == 0) || out_ready);
            r0 = (q0.size() > 0) && out_ready;
            if (q1.size() == 0 && b1 < B1_MAX) b1++;
            if (q0.size() == 0 && b0 < B0_MAX) b0++;
            if (flush) begin
                q1.delete();
                q0.delete();
            end else begin
                if (r1) void'(q1.pop_front());
                if (a1) q1.push_back(e);
                if (r0) void'(q0.pop_front());
                if (a0) q0.push_back(e);
            end
        end
    end

    always @(posedge CLK) begin
        chk("m1_valid", ov1, q1.size() > 0);
        chk("m1_ready", rdy1, q1.size() < 2);
        chk("m1_ctrl", oc1, (q1.size() > 0) ? q1[0].c : '0);
        if (q1.size() > 0) chk("m1_data", od1, q1[0].d);
        chk("m1_bubble", bc1, b1);
        chk("m0_valid", ov0, q0.size() > 0);
        chk("m0_ready", rdy0, (q0.size() == 0) || out_ready);
        chk("m0_ctrl", oc0, (q0.size() > 0) ? q0[0].c : '0);
        if (q0.size() > 0) chk("m0_data", od0, q0[0].d);
        chk("m0_bubble", bc0, b0);
    end

    initial begin
        #1 Resetn = 1'b0;
        repeat (3) step();
        chk("rst_valid", ov1, 0);
        chk("rst_ctrl", oc1, 0);
        chk("rst_data", od1, 0);
        chk("rst_bubble", bc1, 0);
        chk("rst_ready", rdy1, 1);

        // Stream 1..4 at full throughput
        Resetn = 1'b1;
        in_valid = 1'b1;
        in_ctrl = 5'h1F;
        in_data = 1;
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("stream_valid", ov1, 1);
            chk("stream_data", od1, i);
            chk("stream_ctrl", oc1, 5'h1F);
            if (i == 4) chk("stream_bubble", bc1, 1);
            if (i < 4) in_data = DW'(i + 1);
            else in_valid = 1'b0;
        end

        // Control bits with no valid must never reach the output
        in_ctrl = 5'b10001;
        repeat (2) begin
            step();
            chk("mask_ctrl", oc1, 0);
            chk("mask_valid", ov1, 0);
        end

        // Stall: 7 in main, 8 absorbed by skid, 9 held upstream
        in_ctrl = 5'h1F;
        in_valid = 1'b1;
        in_data = 7;
        step();
        chk("stall_d7", od1, 7);
        out_ready = 1'b0;
        in_data = 8;
        step();
        chk("stall_hold7a", od1, 7);
        chk("stall_rdy_lo", rdy1, 0);
        in_data = 9;
        step();
        chk("stall_hold7b", od1, 7);
        chk("stall_rdy_lo2", rdy1, 0);
        out_ready = 1'b1;
        step();
        chk("stall_d8", od1, 8);
        chk("stall_rdy_hi", rdy1, 1);
        step();
        chk("stall_d9", od1, 9);
        in_valid = 1'b0;
        step();
        chk("stall_empty", ov1, 0);

        // Flush while FULL with a concurrent offer
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 'hA;
        step();
        in_data = 'hB;
        step();
        chk("flush_full", rdy1, 0);
        chk("flush_mainA", od1, 'hA);
        in_data = 'hC;
        flush = 1'b1;
        step();
        chk("flush_valid", ov1, 0);
        chk("flush_ctrl", oc1, 0);
        chk("flush_ready", rdy1, 1);
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) begin
            step();
            chk("flush_noC", ov1, 0);
        end

        // Single-entry variant: ready follows out_ready while full
        in_valid = 1'b1;
        in_data = 20;
        step();
        chk("s0_d20", od0, 20);
        out_ready = 1'b0;
        #1;
        chk("s0_rdy_lo", rdy0, 0);
        in_data = 21;
        step();
        chk("s0_hold20", od0, 20);
        out_ready = 1'b1;
        #1;
        chk("s0_rdy_hi", rdy0, 1);
        step();
        chk("s0_d21", od0, 21);
        in_valid = 1'b0;
        step();
        chk("s0_empty", ov0, 0);

        // Async reset between edges while FULL
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 'h30;
        step();
        in_data = 'h31;
        step();
        chk("ar_full", rdy1, 0);
        in_valid = 1'b0;
        #2 Resetn = 1'b0;
        #1;
        chk("ar_valid", ov1, 0);
        chk("ar_ctrl", oc1, 0);
        chk("ar_bubble", bc1, 0);
        step();
        Resetn = 1'b1;
        #1;
        chk("ar_ready", rdy1, 1);
        chk("ar_valid2", ov1, 0);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step();
            in_valid  = ($urandom_range(0, 3) != 0);
            in_ctrl   = CW'($urandom);
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 31) == 0);
        end
        step();
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        repeat (20) step();
        chk("sat_bubble0", bc0, B0_MAX);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised, elastic successor to the fixed EX/MEM stage register; usable between any two CPU pipeline stages.
- Carries a control bundle (MemWr, Branch, Jump, MemtoReg, Regwr, …) and a packed data bundle (busB, ALUout, Target, Rd, …) under a valid/ready handshake.
- Adds stall back-pressure, flush-to-bubble, an optional two-entry skid buffer and a saturating bubble counter for performance monitoring.

Parameters:
- CTRL_W, 5, width of the control bundle; all bits are write/side-effect enables that must be zero in a bubble.
- DATA_W, 128, width of the packed data bundle (default 4 x 32-bit fields).
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
- CNT_W, 16, width of the bubble counter.

Ports:
- CLK  input  1  pipeline clock; all state updates on the falling edge, matching the rest of the pipeline.
- Resetn  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream stage presents an instruction.
- in_ready  output  1  stage can accept this cycle.
- in_ctrl  input  CTRL_W  upstream control bundle.
- in_data  input  DATA_W  upstream data bundle.
- flush  input  1  kill all held instructions (branch/jump resolution).
- out_valid  output  1  downstream entry valid.
- out_ready  input  1  downstream stage accepts (0 = stall).
- out_ctrl  output  CTRL_W  control bundle; forced to 0 whenever out_valid = 0.
- out_data  output  DATA_W  data bundle; don't-care when out_valid = 0.
- bubble_cnt  output  CNT_W  count of falling edges with out_valid = 0, saturating.

Behaviour:
- Reset (Resetn low, asynchronous): main and skid valid = 0; all ctrl registers = 0; all data registers = 0; bubble_cnt = 0; out_valid = 0; out_ctrl = 0; out_data = 0. With SKID = 1, in_ready = 1 from reset release.
- Accept = in_valid & in_ready; retire = out_valid & out_ready; both are evaluated at the falling edge.
- SKID = 1 state: EMPTY (main invalid), ONE (main valid, skid invalid), FULL (both valid).
  - EMPTY + accept -> ONE; data is loaded into main.
  - ONE + accept + retire -> ONE; main is reloaded.
  - ONE + accept + no retire -> FULL; input is loaded into skid.
  - ONE + retire + no accept -> EMPTY.
  - FULL + retire -> ONE; skid moves to main. No accept is possible in FULL.
- in_ready = !skid_valid (registered), so in_ready never depends combinationally on out_ready.
- SKID = 0: single entry; in_ready = !out_valid | out_ready (combinational); accept with retire reloads in the same edge.
- Latency: 1 falling edge from accept to out_valid when empty. There are no bubbles at full throughput (one transfer per cycle while out_ready = 1).
- Ordering: strict FIFO order; no instruction is duplicated or lost except by flush.
- Stall: out_ready = 0 holds out_ctrl and out_data stable. With SKID = 1, one further instruction is absorbed, then in_ready drops.
- flush = 1 at an edge:
  - Both valids clear; ctrl registers are zeroed.
  - Any accept in that same cycle is discarded. The upstream handshake still completes, because the upstream stage is flushed too.
  - flush dominates accept and retire. A retire in the flush cycle still counts as delivered downstream.
- out_ctrl = main_ctrl & {CTRL_W{main_valid}}, so a bubble can never write the register file or memory.
- bubble_cnt increments on every falling edge where out_valid = 0 before the edge. It saturates at 2^CNT_W - 1 and clears only on reset.
- Reset mid-operation: all entries are dropped immediately, without waiting for a clock edge.
- Data registers are not cleared on flush; only valid and ctrl are cleared.

Decomposition:
- Shared package pipe_pkg holds:
  - Control bit index constants: CTRL_MEMWR = 0, CTRL_BRANCH = 1, CTRL_JUMP = 2, CTRL_MEMTOREG = 3, CTRL_REGWR = 4.
  - Data field offsets for busB, ALUout, Target, Rd.
  - Default CTRL_W and DATA_W.
- One sub-module, pipe_entry: a single valid + ctrl + data register with load, clear-ctrl and async reset. It is instantiated twice (main, skid) when SKID = 1 and once when SKID = 0.

Test Plan:
- Reset then stream: in_valid = 1 for 4 cycles, ctrl = 5'h1F, data = 1..4, out_ready = 1 -> out_valid rises 1 edge after the first accept; data 1,2,3,4 on consecutive cycles; bubble_cnt = 1.
- Stall with SKID = 1: hold out_ready = 0 after data = 7 is in main, offer 8 and 9 -> 8 lands in skid, in_ready = 0, 9 is held upstream; release out_ready -> outputs 7, 8, 9 in order, no loss.
- Flush in FULL state: main = 0xA, skid = 0xB, flush = 1 with in_valid = 1 (0xC) -> next edge out_valid = 0, out_ctrl = 0, in_ready = 1; 0xC never appears.
- Bubble masking: in_ctrl = 5'b10001 with in_valid = 0 -> out_ctrl stays 0, no write enables seen downstream.
- SKID = 0 back-to-back: out_ready toggles 1,0,1 with continuous input -> in_ready follows out_ready combinationally while full; exact order preserved.
- Async reset mid-stream: assert Resetn = 0 between clock edges while FULL -> out_valid and out_ctrl drop to 0 immediately; bubble_cnt = 0; in_ready = 1 after release.
